// File: rtl/serial_parity_rx_pkg.sv
// Shared types and constants for the serial parity receiver.
package serial_parity_rx_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StHold   = 2'd3
  } state_e;

  // Parity-error counter width and its saturation value.
  localparam int unsigned            ErrCntWidth = 8;
  localparam logic [ErrCntWidth-1:0] ErrCntMax   = 8'hFF;

endpackage

// File: rtl/parity_shift_acc.sv
// Datapath for serial_parity_rx: LSB-first shift register plus running parity XOR.
module parity_shift_acc #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [Width-1:0] data_o,
  output logic             parity_o
);

  logic [Width-1:0] sr_q, sr_d, sr_shift;
  logic             acc_q, acc_d;

  // New bits enter at the MSB so the first bit received ends up in bit 0.
  if (Width == 1) begin : g_w1
    assign sr_shift = bit_i;
  end else begin : g_wn
    assign sr_shift = {bit_i, sr_q[Width-1:1]};
  end

  // Next-state: clear on frame start, shift and accumulate on each data bit.
  always_comb begin
    sr_d  = sr_q;
    acc_d = acc_q;
    if (clr_i) begin
      sr_d  = '0;
      acc_d = 1'b0;
    end else if (shift_i) begin
      sr_d  = sr_shift;
      acc_d = acc_q ^ bit_i;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q  <= '0;
      acc_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      acc_q <= acc_d;
    end
  end

  assign data_o   = sr_q;
  assign parity_o = acc_q;

endmodule

// File: rtl/serial_parity_rx.sv
// Serial receiver: start bit, WIDTH data bits LSB first, one even-parity bit.
// Delivers each word with a parity-error flag on a valid/ready port.
// Optional: define SERIAL_PARITY_RX_ERR_CNT_EN for a saturating parity-error counter.
module serial_parity_rx
  import serial_parity_rx_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  input  logic             in_bit_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_err_o
`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  ,
  output logic [ErrCntWidth-1:0] err_cnt_o
`endif
);

  localparam int unsigned CntWidth = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(WIDTH - 1);

  localparam logic [1:0] StateIdle   = StIdle;
  localparam logic [1:0] StateData   = StData;
  localparam logic [1:0] StateParity = StParity;
  localparam logic [1:0] StateHold   = StHold;

  logic [1:0]          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic                out_err_q, out_err_d;

  logic             accept;
  logic             clr;
  logic             shift;
  logic [WIDTH-1:0] sr_data;
  logic             acc_parity;
  logic             par_err;
  logic             frame_done;

  assign accept     = in_valid_i && in_ready_q;
  assign par_err    = acc_parity ^ in_bit_i;
  assign frame_done = (state_q == StateParity) && accept;

  parity_shift_acc #(
    .Width (WIDTH)
  ) u_datapath (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (clr),
    .shift_i  (shift),
    .bit_i    (in_bit_i),
    .data_o   (sr_data),
    .parity_o (acc_parity)
  );

  // FSM next-state, bit counter and output capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    clr        = 1'b0;
    shift      = 1'b0;
    unique case (state_q)
      StateIdle: begin
        // Zeros in idle are line noise, only a 1 starts a frame.
        if (accept && in_bit_i) begin
          state_d = StateData;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      StateData: begin
        if (accept) begin
          shift = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntLast) begin
            state_d = StateParity;
          end
        end
      end
      StateParity: begin
        if (accept) begin
          out_data_d = sr_data;
          out_err_d  = par_err;
          state_d    = StateHold;
        end
      end
      StateHold: begin
        if (out_ready_i) begin
          state_d = StateIdle;
        end
      end
      default: state_d = StateIdle;
    endcase
    in_ready_d  = (state_d != StateHold);
    out_valid_d = (state_d == StateHold);
  end

  // Control and output registers; handshake outputs are registered copies of state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StateIdle;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_err_o   = out_err_q;

`ifdef SERIAL_PARITY_RX_ERR_CNT_EN
  logic [ErrCntWidth-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of frames delivered with a parity error.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_done && par_err && (err_cnt_q != ErrCntMax)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // Error counter register, cleared only by reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: doc/serial_parity_rx.md
# serial_parity_rx

Serial receiver that checks the parity of each incoming frame. It sits at the receiving end of a one-bit serial link: start bit, WIDTH data bits LSB first, then one even-parity bit. It shifts in the bits and recomputes parity as a running XOR. It then presents the assembled word, with a parity-error flag, on a valid/ready output port.

## Interface
- WIDTH, 8 — data bits per frame; legal range 1..32.
- clk  input  1  — single clock, all state on rising edge.
- rst  input  1  — asynchronous, active-high reset.
- in_valid  input  1  — in_bit is meaningful this cycle.
- in_bit  input  1  — serial bit.
- in_ready  output  1  — receiver accepts a bit this cycle.
- out_valid  output  1  — out_data/out_err hold a completed frame.
- out_ready  input  1  — consumer takes the frame this cycle.
- out_data  output  WIDTH  — received word; bit 0 = first data bit.
- out_err  output  1  — 1 when the frame's parity check failed.
- err_cnt  output  8  — present only with SERIAL_PARITY_RX_ERR_CNT_EN.

## Operation
- Bit acceptance: a bit is accepted when in_valid && in_ready.
- in_ready = 1 in IDLE, DATA and PARITY; 0 in HOLD.
- IDLE:
  - Accepted bit 1 (start bit) → DATA; clear bit counter and parity accumulator.
  - Accepted bit 0 is discarded; state stays IDLE.
- DATA:
  - Each accepted bit shifts into the shift register, so the first bit ends up in out_data[0].
  - Each accepted bit XORs into the parity accumulator and increments the counter.
  - The WIDTH-th accepted bit → PARITY.
- PARITY:
  - The accepted bit XORs into the accumulator.
  - The result is registered as out_err (even parity: total XOR must be 0).
  - out_data is loaded from the shift register; state → HOLD.
- HOLD:
  - out_valid = 1; out_data/out_err are stable.
  - out_valid && out_ready → IDLE.
  - Input bits are not accepted (in_ready = 0).
- Cycles with in_valid = 0 do not advance the state machine; gaps of any length are allowed mid-frame.
- Frames with parity errors are still delivered; only out_err flags them.
- Counter width is max(1, $clog2(WIDTH+1)) bits; it never wraps within a frame.

## Timing
- Reset values:
  - State is IDLE.
  - in_ready = 1, out_valid = 0, out_data = 0, out_err = 0, err_cnt = 0.
  - Shift register, counter and accumulator are cleared.
- Latency: parity bit accepted at edge N → out_valid = 1 after edge N, visible in cycle N+1.
- Minimum frame period is WIDTH+3 cycles: start bit, WIDTH data bits, parity bit, one HOLD cycle with out_ready = 1.
- out_ready asserted outside HOLD is ignored.
- In HOLD with out_ready = 1 and in_valid = 1 in the same cycle, the bit is dropped. in_ready returns to 1 the following cycle.
- rst asserted mid-frame or in HOLD returns to IDLE immediately; the partial or pending frame is lost and out_valid drops asynchronously.
- in_ready, out_valid, out_data and out_err come straight from registers; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_PARITY_RX_ERR_CNT_EN defined:
  - The err_cnt port and an 8-bit saturating counter exist.
  - The counter increments on the PARITY→HOLD transition when the computed error is 1.
  - It holds at 255 and is cleared only by rst.
- Not defined: no err_cnt port and no counter logic; all other behaviour is identical.

## Structure
- serial_parity_rx_pkg holds:
  - the state enum typedef (IDLE, DATA, PARITY, HOLD);
  - the error-counter width constant (8) and its saturation value.
- Sub-module parity_shift_acc carries the datapath: WIDTH-bit shift register plus parity XOR accumulator, with clear and shift-enable inputs. The top level keeps only the FSM, counter and handshake.

## Test plan
- WIDTH=8, out_ready=1; send 1, then 0xA5 LSB first (1,0,1,0,0,1,0,1), then parity 0 → out_data=0xA5, out_err=0, out_valid for 1 cycle, 11 cycles after the start bit.
- Same frame with parity bit 1 → out_data=0xA5, out_err=1; with the macro, err_cnt=1.
- Frame 0x3C with random in_valid gaps (1–4 idle cycles between bits) and leading 0 bits in IDLE → out_data=0x3C, out_err=0; leading zeros ignored.
- Frame 0xFF, parity 0, out_ready held 0 for 5 cycles while in_valid=1 with bits 1 → out_valid stays 1, in_ready=0, data stable; after out_ready pulse, the next start bit is accepted and a new frame decodes correctly.
- rst pulse after the 4th data bit of 0x81, then full frame 0x42 → only 0x42 is delivered, out_err=0, no stray out_valid.
- Macro on: 300 consecutive bad-parity frames → err_cnt saturates at 255 and stays there; rst clears it to 0.
